// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB3 initiator bridge.
// The package holds the FSM state enum, the read data returned on an error, and the timeout counter width.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_e;

  localparam logic [31:0] APB_ERR_RDATA = 32'h0;

  // A disabled timeout still gets a 1-bit counter so the vector stays legal.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle between one initiator (master) and the peripheral side (slave).
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Core request/grant/response to single APB3 transfers, with wait-state handling,
// PSLVERR forwarding and an ACCESS-phase timeout against hung slaves.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       req_i,
  input  logic [31:0]                add_i,
  input  logic                       we_i,
  input  logic [31:0]                wdata_i,
  output logic                       gnt_o,
  output logic                       r_valid_o,
  output logic [31:0]                r_rdata_o,
  output logic                       r_opc_o,
  apb_master_bridge_if.master        apb
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  apb_master_state_e         state_reg, state_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [31:0]               pwdata_reg;
  logic                      pwrite_reg;
  logic [31:0]               rdata_reg;
  logic                      opc_reg;
  logic [CNT_W-1:0]          tmo_cnt_reg;
  logic                      gnt;
  logic                      tmo_hit;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
    if (APB_ADDR_WIDTH < 32) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^add_i[31:APB_ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    gnt        = 1'b0;
    case (state_reg)
      IDLE, RESP: begin
        gnt        = req_i;
        state_next = req_i ? SETUP : IDLE;
      end
      SETUP:   state_next = ACCESS;
      ACCESS:  if (apb.PREADY || tmo_hit) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg   <= IDLE;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pwrite_reg  <= 1'b0;
      rdata_reg   <= '0;
      opc_reg     <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Bus attributes are latched at grant so they stay put through IDLE/RESP.
      if (gnt) begin
        paddr_reg  <= add_i[APB_ADDR_WIDTH-1:0];
        pwrite_reg <= we_i;
        pwdata_reg <= we_i ? wdata_i : 32'h0;
      end
      if (state_reg == SETUP) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == ACCESS && !apb.PREADY) begin
        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
      end
      // A slave that answers in the abort cycle still completes normally.
      if (state_reg == ACCESS) begin
        if (apb.PREADY) begin
          rdata_reg <= pwrite_reg ? 32'h0 : apb.PRDATA;
          opc_reg   <= apb.PSLVERR;
        end else if (tmo_hit) begin
          rdata_reg <= APB_ERR_RDATA;
          opc_reg   <= 1'b1;
        end
      end
    end
  end

  assign gnt_o       = gnt;
  assign r_valid_o   = (state_reg == RESP);
  assign r_rdata_o   = rdata_reg;
  assign r_opc_o     = opc_reg;
  assign apb.PADDR   = paddr_reg;
  assign apb.PWDATA  = pwdata_reg;
  assign apb.PWRITE  = pwrite_reg;
  assign apb.PSEL    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign apb.PENABLE = (state_reg == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge: a plan-driven APB slave,
// a transfer-level reference model, and a response monitor.
module tb_apb_master_bridge;

  localparam int AW  = 12;
  localparam int TMO = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          w;      // PREADY=0 cycles the slave inserts before answering
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        gnt, r_valid, r_opc;
  logic [31:0] r_rdata;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          nresp = 0;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  apb_master_bridge_if #(.ADDR_WIDTH(AW)) apb();

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .req_i(req),
    .add_i(add),
    .we_i(we),
    .wdata_i(wdata),
    .gnt_o(gnt),
    .r_valid_o(r_valid),
    .r_rdata_o(r_rdata),
    .r_opc_o(r_opc),
    .apb(apb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one transfer's response derived from the slave plan.
  function automatic exp_t model(input plan_t p, input int g);
    exp_t e;
    int   alen;
    if (p.w + 1 > TMO) begin
      alen    = TMO;
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else begin
      alen    = p.w + 1;
      e.rdata = p.we ? 32'h0 : p.rdata;
      e.err   = p.err;
    end
    e.gcyc = g;
    e.lat  = 2 + alen;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the grant.
  task automatic issue(input plan_t p, output int gcyc);
    bit granted = 0;
    req   = 1'b1;
    add   = p.addr;
    we    = p.we;
    wdata = p.wdata;
    gcyc  = -1;
    for (int i = 0; i < 100 && !granted; i++) begin
      #1;
      chk("gnt", {31'h0, gnt}, {31'h0, exp_q.size() == 0});
      if (gnt) begin
        granted = 1;
        gcyc    = cyc;
        plan_q.push_back(p);
        exp_q.push_back(model(p, cyc));
      end
      @(negedge clk);
    end
    if (!granted) chk("gnt_wait", 32'h0, 32'h1);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // APB slave: follows the plan queue, drives junk whenever the bridge must ignore the bus.
  initial begin
    plan_t cur;
    int    k = 0;
    bit    prev_setup = 0;
    bit    ready;
    cur = '{addr: 0, we: 0, wdata: 0, w: 0, err: 0, rdata: 0};
    apb.PREADY  = 1'b0;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_setup) chk("setup_to_access", {30'h0, apb.PSEL, apb.PENABLE}, 32'h3);
      prev_setup = apb.PSEL && !apb.PENABLE;
      if (apb.PSEL && !apb.PENABLE) begin
        k = 0;
        if (plan_q.size() == 0) chk("plan_avail", 32'h0, 32'h1);
        else cur = plan_q.pop_front();
        chk("paddr", {20'h0, apb.PADDR}, {20'h0, cur.addr[AW-1:0]});
        chk("pwrite", {31'h0, apb.PWRITE}, {31'h0, cur.we});
        chk("pwdata", apb.PWDATA, cur.we ? cur.wdata : 32'h0);
        apb.PREADY  = 1'($urandom_range(0, 1));
        apb.PRDATA  = $urandom;
        apb.PSLVERR = 1'($urandom_range(0, 1));
      end else if (apb.PSEL && apb.PENABLE) begin
        k++;
        if (k > TMO) chk("access_len", k, TMO);
        chk("paddr_hold", {20'h0, apb.PADDR}, {20'h0, cur.addr[AW-1:0]});
        chk("pwdata_hold", apb.PWDATA, cur.we ? cur.wdata : 32'h0);
        ready       = (k == cur.w + 1);
        apb.PREADY  = ready;
        apb.PRDATA  = ready ? cur.rdata : $urandom;
        apb.PSLVERR = ready ? cur.err : 1'($urandom_range(0, 1));
      end else begin
        k           = 0;
        apb.PREADY  = 1'($urandom_range(0, 1));
        apb.PRDATA  = $urandom;
        apb.PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", {31'h0, r_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          nresp++;
          $display("resp %0d: rdata=%h opc=%b latency=%0d", nresp, r_rdata, r_opc, cyc - e.gcyc);
          chk("r_rdata", r_rdata, e.rdata);
          chk("r_opc", {31'h0, r_opc}, {31'h0, e.err});
          chk("latency", cyc - e.gcyc, e.lat);
          chk("resp_psel", {30'h0, apb.PSEL, apb.PENABLE}, 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    int    g0, g1, g2, gap;

    repeat (3) @(negedge clk);
    chk("rst_psel", {31'h0, apb.PSEL}, 32'h0);
    chk("rst_penable", {31'h0, apb.PENABLE}, 32'h0);
    chk("rst_rvalid", {31'h0, r_valid}, 32'h0);
    chk("rst_rdata", r_rdata, 32'h0);
    chk("rst_opc", {31'h0, r_opc}, 32'h0);
    chk("rst_paddr", {20'h0, apb.PADDR}, 32'h0);
    chk("rst_pwdata", apb.PWDATA, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    p = '{addr: 32'h0000_0008, we: 1'b0, wdata: 32'h0, w: 0, err: 1'b0, rdata: 32'h1234_5678};
    issue(p, g0); drain();
    p = '{addr: 32'h0000_0010, we: 1'b1, wdata: 32'hA5A5_A5A5, w: 3, err: 1'b0, rdata: 32'hFFFF_0000};
    issue(p, g0); drain();
    p = '{addr: 32'hFFFF_F123, we: 1'b0, wdata: 32'h0, w: 1, err: 1'b1, rdata: 32'hDEAD_BEEF};
    issue(p, g0); drain();
    p = '{addr: 32'h0000_0020, we: 1'b0, wdata: 32'h0, w: 100, err: 1'b0, rdata: 32'h7777_7777};
    issue(p, g0); drain();
    p = '{addr: 32'h0000_0024, we: 1'b0, wdata: 32'h0, w: 3, err: 1'b0, rdata: 32'h8888_8888};
    issue(p, g0); drain();

    // Continuous request: grants every third cycle.
    p = '{addr: 32'h0000_0100, we: 1'b0, wdata: 32'h0, w: 0, err: 1'b0, rdata: 32'h0000_0001};
    issue(p, g0);
    p.addr = 32'h0000_0104; p.we = 1'b1; p.wdata = 32'hCAFE_0002;
    issue(p, g1);
    p.addr = 32'h0000_0108; p.we = 1'b0; p.rdata = 32'h0000_0003;
    issue(p, g2);
    chk("b2b_gap1", g1 - g0, 3);
    chk("b2b_gap2", g2 - g1, 3);
    drain();

    // Reset in the second ACCESS cycle drops the transfer silently.
    p = '{addr: 32'h0000_0040, we: 1'b0, wdata: 32'h0, w: 100, err: 1'b0, rdata: 32'h55};
    issue(p, g0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_psel", {31'h0, apb.PSEL}, 32'h0);
    chk("mid_rst_penable", {31'h0, apb.PENABLE}, 32'h0);
    chk("mid_rst_rvalid", {31'h0, r_valid}, 32'h0);
    exp_q.delete();
    plan_q.delete();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_psel", {31'h0, apb.PSEL}, 32'h0);
      chk("post_rst_rvalid", {31'h0, r_valid}, 32'h0);
    end
    p = '{addr: 32'h0000_0044, we: 1'b0, wdata: 32'h0, w: 0, err: 1'b0, rdata: 32'h4444_0044};
    issue(p, g0); drain();

    for (int n = 0; n < 150; n++) begin
      p.addr  = $urandom;
      p.we    = 1'($urandom_range(0, 1));
      p.wdata = $urandom;
      p.rdata = $urandom;
      p.err   = ($urandom_range(0, 3) == 0);
      p.w     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      gap     = int'($urandom_range(0, 2));
      issue(p, g0);
      repeat (gap) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
